regfile_wb_arbiter: RTL and testbench

- Write-port arbiter and scoreboard for the 16x32 register file.
- Shares the single register-file write port between two writeback requesters: req0 = ALU writeback, req1 = memory/load writeback. Round-robin arbitration is used.
- Drives the register file's write-enable, write-address and write-data inputs from flops.
- Keeps one pending bit per register, so the issue stage can stall on operands whose writeback has not yet happened.

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a per-register pending scoreboard.
// Write port is registered (1 cycle after accept); readies are combinational, at most one per cycle, and 0 in reset.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb0_valid,
  input  logic [ADDR_W-1:0]    wb0_dir,
  input  logic [DATA_W-1:0]    wb0_data,
  output logic                 wb0_ready,
  input  logic                 wb1_valid,
  input  logic [ADDR_W-1:0]    wb1_dir,
  input  logic [DATA_W-1:0]    wb1_data,
  output logic                 wb1_ready,
  input  logic                 mark_valid,
  input  logic [ADDR_W-1:0]    mark_dir,
  input  logic [ADDR_W-1:0]    dirA,
  input  logic [ADDR_W-1:0]    dirB,
  output logic                 busyA,
  output logic                 busyB,
  output logic                 reg_write,
  output logic [ADDR_W-1:0]    dir_WR,
  output logic [DATA_W-1:0]    data_in,
  output logic [2**ADDR_W-1:0] pending,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int NREG = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic             last_grant_q, last_grant_d;
  logic             reg_write_q, reg_write_d;
  wr_t              wr_q, wr_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant0, grant1, xfer;
  wr_t  win;

  // last_grant_q == 1 means req1 won last time, so req0 takes the next conflict.
  always_comb begin
    grant0    = wb0_valid & (~wb1_valid | last_grant_q);
    grant1    = wb1_valid & (~wb0_valid | ~last_grant_q);
    wb0_ready = grant0 & ~rst;
    wb1_ready = grant1 & ~rst;
    xfer      = wb0_ready | wb1_ready;
    win.dir   = wb0_ready ? wb0_dir  : wb1_dir;
    win.data  = wb0_ready ? wb0_data : wb1_data;
  end

  always_comb begin
    reg_write_d  = xfer;
    wr_d         = xfer ? win : wr_q;
    last_grant_d = xfer ? wb1_ready : last_grant_q;

    // Clear first, then mark: a newer producer on the same register keeps it pending.
    pending_d = pending_q;
    if (xfer) begin
      pending_d[win.dir] = 1'b0;
    end
    if (mark_valid) begin
      pending_d[mark_dir] = 1'b1;
    end

    cnt_d = cnt_q;
    if (wb0_valid && wb1_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      wr_q         <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      wr_q         <= wr_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
    end
  end

  // No bypass: the issue stage sees a clear in the same cycle the data is written.
  assign busyA        = pending_q[dirA];
  assign busyB        = pending_q[dirB];
  assign reg_write    = reg_write_q;
  assign dir_WR       = wr_q.dir;
  assign data_in      = wr_q.data;
  assign pending      = pending_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: scenario tasks plus an arbitration model feeding a write scoreboard.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb0_valid = 0, wb1_valid = 0, mark_valid = 0;
  logic [AW-1:0] wb0_dir = '0, wb1_dir = '0, mark_dir = '0, dirA = '0, dirB = '0;
  logic [DW-1:0] wb0_data = '0, wb1_data = '0;

  logic          wb0_ready, wb1_ready, busyA, busyB, reg_write;
  logic [AW-1:0] dir_WR;
  logic [DW-1:0] data_in;
  logic [15:0]   pending;
  logic [15:0]   conflict_cnt;

  logic          s_wb0_ready, s_wb1_ready, s_busyA, s_busyB, s_reg_write;
  logic [AW-1:0] s_dir_WR;
  logic [DW-1:0] s_data_in;
  logic [15:0]   s_pending;
  logic [3:0]    s_cnt;

  int tests = 0;
  int fails = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic             m_lg = 1'b1;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_dir(wb0_dir), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_dir(wb1_dir), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .mark_valid(mark_valid), .mark_dir(mark_dir), .dirA(dirA), .dirB(dirB),
    .busyA(busyA), .busyB(busyB), .reg_write(reg_write), .dir_WR(dir_WR),
    .data_in(data_in), .pending(pending), .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_dir(wb0_dir), .wb0_data(wb0_data), .wb0_ready(s_wb0_ready),
    .wb1_valid(wb1_valid), .wb1_dir(wb1_dir), .wb1_data(wb1_data), .wb1_ready(s_wb1_ready),
    .mark_valid(mark_valid), .mark_dir(mark_dir), .dirA(dirA), .dirB(dirB),
    .busyA(s_busyA), .busyB(s_busyB), .reg_write(s_reg_write), .dir_WR(s_dir_WR),
    .data_in(s_data_in), .pending(s_pending), .conflict_cnt(s_cnt)
  );

  // Arbitration model: predicts readies and pushes the expected write.
  always @(negedge clk) begin
    logic e0, e1;
    if (rst) begin
      m_lg = 1'b1;
    end else begin
      e0 = wb0_valid && (!wb1_valid || m_lg);
      e1 = wb1_valid && !e0;
      tests++;
      if (wb0_ready !== e0 || wb1_ready !== e1) begin
        fails++;
        $display("FAIL arb_ready: got r0=%b r1=%b, expected r0=%b r1=%b at %0t",
                 wb0_ready, wb1_ready, e0, e1, $time);
      end
      if (e0) begin
        exp_q.push_back({wb0_dir, wb0_data});
        m_lg = 1'b0;
      end else if (e1) begin
        exp_q.push_back({wb1_dir, wb1_data});
        m_lg = 1'b1;
      end
    end
  end

  // Write-port scoreboard: each accepted request must appear one posedge later.
  always @(posedge clk) begin
    logic             rst_s;
    logic [AW+DW-1:0] e;
    rst_s = rst;
    #2;
    tests++;
    if (rst_s) begin
      exp_q.delete();
      if (reg_write !== 1'b0) begin
        fails++;
        $display("FAIL wr_after_reset: reg_write=%b, expected 0", reg_write);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (reg_write !== 1'b1 || dir_WR !== e[AW+DW-1:DW] || data_in !== e[DW-1:0]) begin
        fails++;
        $display("FAIL wr_port: got we=%b dir=%0d data=%h, expected we=1 dir=%0d data=%h",
                 reg_write, dir_WR, data_in, e[AW+DW-1:DW], e[DW-1:0]);
      end
    end else if (reg_write !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle: reg_write=%b, expected 0", reg_write);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; wb0_valid = 1; wb1_valid = 1; wb0_dir = 4'd9; wb1_dir = 4'd10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_ready: r0=%b r1=%b, expected 0 0", wb0_ready, wb1_ready);
      end
      tick();
    end
    rst = 0; wb0_valid = 0; wb1_valid = 0;
    @(negedge clk);
    tests++;
    if (reg_write !== 1'b0 || pending !== 16'h0 || conflict_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: we=%b pending=%h cnt=%0d, expected 0 0 0",
               reg_write, pending, conflict_cnt);
    end
    tick();
  endtask

  task automatic test_contention();
    wb0_valid = 1; wb0_dir = 4'd1; wb0_data = 32'hA000_0001;
    wb1_valid = 1; wb1_dir = 4'd2; wb1_data = 32'hB000_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (wb0_ready !== (i % 2 == 0) || wb1_ready !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL contention_grant%0d: r0=%b r1=%b, expected r0=%b", i,
                 wb0_ready, wb1_ready, (i % 2 == 0));
      end
      if (i > 0) begin
        tests++;
        if (dir_WR !== ((i % 2 == 1) ? 4'd1 : 4'd2)) begin
          fails++;
          $display("FAIL contention_dir%0d: dir_WR=%0d, expected %0d", i, dir_WR,
                   (i % 2 == 1) ? 1 : 2);
        end
      end
      tick();
      if (i % 2 == 0) wb0_data = wb0_data + 1;
      else            wb1_data = wb1_data + 1;
    end
    wb0_valid = 0; wb1_valid = 0;
    @(negedge clk);
    tests++;
    if (dir_WR !== 4'd2 || conflict_cnt !== 16'd4 || pending !== 16'h0) begin
      fails++;
      $display("FAIL contention_end: dir_WR=%0d cnt=%0d pending=%h, expected 2 4 0000",
               dir_WR, conflict_cnt, pending);
    end
    tick();
  endtask

  task automatic test_single();
    wb0_valid = 1; wb0_dir = 4'd5; wb0_data = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_ready: r0=%b r1=%b, expected 1 0", wb0_ready, wb1_ready);
    end
    tick();
    wb0_valid = 0; wb0_data = 32'h0;
    @(negedge clk);
    tests++;
    if (reg_write !== 1'b1 || dir_WR !== 4'd5 || data_in !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_write: we=%b dir=%0d data=%h, expected 1 5 deadbeef",
               reg_write, dir_WR, data_in);
    end
    tick();
    @(negedge clk);
    tests++;
    if (reg_write !== 1'b0 || dir_WR !== 4'd5 || data_in !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_hold: we=%b dir=%0d data=%h, expected 0 5 deadbeef",
               reg_write, dir_WR, data_in);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    mark_valid = 1; mark_dir = 4'd7; dirA = 4'd7; dirB = 4'd6;
    @(negedge clk);
    tests++;
    if (busyA !== 1'b0) begin
      fails++;
      $display("FAIL sb_before_mark: busyA=%b, expected 0", busyA);
    end
    tick();
    mark_valid = 0;
    @(negedge clk);
    tests++;
    if (busyA !== 1'b1 || busyB !== 1'b0 || pending !== 16'h0080) begin
      fails++;
      $display("FAIL sb_marked: busyA=%b busyB=%b pending=%h, expected 1 0 0080",
               busyA, busyB, pending);
    end
    tick();
    wb1_valid = 1; wb1_dir = 4'd7; wb1_data = 32'h7777_0007;
    @(negedge clk);
    tests++;
    if (busyA !== 1'b1) begin
      fails++;
      $display("FAIL sb_no_bypass: busyA=%b, expected 1", busyA);
    end
    tick();
    wb1_valid = 0;
    @(negedge clk);
    tests++;
    if (busyA !== 1'b0 || reg_write !== 1'b1 || dir_WR !== 4'd7) begin
      fails++;
      $display("FAIL sb_cleared: busyA=%b we=%b dir=%0d, expected 0 1 7", busyA, reg_write, dir_WR);
    end
    tick();
  endtask

  task automatic test_mark_clear();
    mark_valid = 1; mark_dir = 4'd3; dirB = 4'd3;
    tick();
    wb0_valid = 1; wb0_dir = 4'd3; wb0_data = 32'h3333_0003;
    @(negedge clk);
    tests++;
    if (pending[3] !== 1'b1 || wb0_ready !== 1'b1) begin
      fails++;
      $display("FAIL mc_setup: pending3=%b r0=%b, expected 1 1", pending[3], wb0_ready);
    end
    tick();
    mark_valid = 0;
    @(negedge clk);
    tests++;
    if (pending[3] !== 1'b1 || busyB !== 1'b1) begin
      fails++;
      $display("FAIL mc_set_wins: pending3=%b busyB=%b, expected 1 1", pending[3], busyB);
    end
    tick();
    wb0_valid = 0;
    @(negedge clk);
    tests++;
    if (pending !== 16'h0000 || busyB !== 1'b0) begin
      fails++;
      $display("FAIL mc_clear: pending=%h busyB=%b, expected 0000 0", pending, busyB);
    end
    tick();
  endtask

  task automatic test_saturation();
    rst = 1; wb0_valid = 1; wb1_valid = 1;
    wb0_dir = 4'd11; wb0_data = 32'h1100_0000; wb1_dir = 4'd12; wb1_data = 32'h1200_0000;
    @(negedge clk);
    tests++;
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ready: r0=%b r1=%b, expected 0 0", wb0_ready, wb1_ready);
    end
    tick();
    rst = 0;
    @(negedge clk);
    tests++;
    if (reg_write !== 1'b0 || s_cnt !== 4'd0) begin
      fails++;
      $display("FAIL midreset_state: we=%b cnt=%0d, expected 0 0", reg_write, s_cnt);
    end
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 16) begin
        tests++;
        if (s_cnt !== 4'd15) begin
          fails++;
          $display("FAIL sat_reach: cnt=%0d, expected 15", s_cnt);
        end
      end
      tick();
      wb0_data = wb0_data + 1;
      wb1_data = wb1_data + 1;
    end
    wb0_valid = 0; wb1_valid = 0;
    @(negedge clk);
    tests++;
    if (s_cnt !== 4'd15 || conflict_cnt !== 16'd20) begin
      fails++;
      $display("FAIL sat_hold: cnt4=%0d cnt16=%0d, expected 15 20", s_cnt, conflict_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_scoreboard();
    test_mark_clear();
    test_saturation();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
